// File: rtl/wb_retire_queue.sv
// wb_retire_queue: in-order writeback/retire queue between the MEM stage and the
// regfile, CSR file and debug trace port.
//
// Accepts MEM results into a DEPTH-entry FIFO. It retires at most one entry per
// cycle from the head. An exception or ertn at retire flushes every queued entry.
// Pending register writes are forwarded to decode.
//
// Optional feature: define WB_TRACE_STALL_EN to make retire wait for trace_ready.
// Without it, trace_ready is ignored and the head retires every cycle it is valid.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   in_valid / in_ready         MEM handshake (in_ready is WB_allowin)
//   in_*                        instruction payload from MEM
//   cnt_tid                     counter/TID value substituted for rfrom_cntid results
//   rf_we/rf_waddr/rf_wdata     regfile write port
//   csr_we/csr_num/csr_wvalue/csr_wmask   CSR write port
//   wb_ex/wb_ecode/wb_esubcode/wb_pc/wb_vaddr   exception report
//   ertn_flush                  ertn retiring
//   fwd_raddr / fwd_hit / fwd_data   forwarding lookup for decode
//   trace_ready                 trace sink accepts (used with WB_TRACE_STALL_EN)
//   debug_wb_*                  trace of the retiring entry
//   occupancy                   number of valid entries
module wb_retire_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  // MEM stage interface
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic [DATA_W-1:0]         in_result,
  input  logic [DATA_W-1:0]         in_vaddr,
  input  logic                      in_gr_we,
  input  logic [DEST_W-1:0]         in_dest,
  input  logic                      in_rfrom_cntid,
  input  logic                      in_csr_we,
  input  logic [13:0]               in_csr_num,
  input  logic [DATA_W-1:0]         in_csr_wvalue,
  input  logic [DATA_W-1:0]         in_csr_wmask,
  input  logic                      in_ex,
  input  logic [5:0]                in_ecode,
  input  logic [8:0]                in_esubcode,
  input  logic                      in_ertn,
  input  logic [DATA_W-1:0]         cnt_tid,
  // regfile write port
  output logic                      rf_we,
  output logic [DEST_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  // CSR write port
  output logic                      csr_we,
  output logic [13:0]               csr_num,
  output logic [DATA_W-1:0]         csr_wvalue,
  output logic [DATA_W-1:0]         csr_wmask,
  // exception / ertn report
  output logic                      wb_ex,
  output logic [5:0]                wb_ecode,
  output logic [8:0]                wb_esubcode,
  output logic [DATA_W-1:0]         wb_pc,
  output logic [DATA_W-1:0]         wb_vaddr,
  output logic                      ertn_flush,
  // forwarding to decode
  input  logic [DEST_W-1:0]         fwd_raddr,
  output logic                      fwd_hit,
  output logic [DATA_W-1:0]         fwd_data,
  // debug trace
  input  logic                      trace_ready,
  output logic [DATA_W-1:0]         debug_wb_pc,
  output logic [3:0]                debug_wb_rf_we,
  output logic [DEST_W-1:0]         debug_wb_rf_wnum,
  output logic [DATA_W-1:0]         debug_wb_rf_wdata,
  // status
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] vaddr;
    logic              gr_we;
    logic [DEST_W-1:0] dest;
    logic              rfrom_cntid;
    logic              csr_we;
    logic [13:0]       csr_num;
    logic [DATA_W-1:0] csr_wvalue;
    logic [DATA_W-1:0] csr_wmask;
    logic              ex;
    logic [5:0]        ecode;
    logic [8:0]        esubcode;
    logic              ertn;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             in_entry;
  entry_t             hd;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic               head_valid;
  logic               trace_ok;
  logic               retire;
  logic               push;
  logic               flush;
  logic [DATA_W-1:0]  head_wdata;

  // Pack the incoming MEM payload
  always_comb begin
    in_entry             = '0;
    in_entry.pc          = in_pc;
    in_entry.result      = in_result;
    in_entry.vaddr       = in_vaddr;
    in_entry.gr_we       = in_gr_we;
    in_entry.dest        = in_dest;
    in_entry.rfrom_cntid = in_rfrom_cntid;
    in_entry.csr_we      = in_csr_we;
    in_entry.csr_num     = in_csr_num;
    in_entry.csr_wvalue  = in_csr_wvalue;
    in_entry.csr_wmask   = in_csr_wmask;
    in_entry.ex          = in_ex;
    in_entry.ecode       = in_ecode;
    in_entry.esubcode    = in_esubcode;
    in_entry.ertn        = in_ertn;
  end

`ifdef WB_TRACE_STALL_EN
  assign trace_ok = trace_ready;
`else
  logic unused_trace_ready;
  assign unused_trace_ready = trace_ready;
  assign trace_ok           = 1'b1;
`endif

  assign hd         = mem[head];
  assign head_valid = (count != '0);
  // Retire is held off in the reset cycle so no write escapes while the queue is discarded
  assign retire     = resetn & head_valid & trace_ok;
  // A full queue can still accept when its head leaves in the same cycle
  assign in_ready   = (count < CNT_W'(DEPTH)) | retire;
  assign push       = in_valid & in_ready;
  assign flush      = retire & (hd.ex | hd.ertn);

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Younger entries and any same-cycle push are dropped
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= in_entry;
        tail      <= tail + PTR_W'(1);
      end
      if (retire) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(retire);
    end
  end

  assign head_wdata = hd.rfrom_cntid ? cnt_tid : hd.result;

  // Retire-side outputs come straight from the head entry
  always_comb begin
    rf_we             = retire & hd.gr_we & ~hd.ex & ~hd.ertn;
    rf_waddr          = hd.dest;
    rf_wdata          = head_wdata;
    csr_we            = retire & hd.csr_we & ~hd.ex & ~hd.ertn;
    csr_num           = hd.csr_num;
    csr_wvalue        = hd.csr_wvalue;
    csr_wmask         = hd.csr_wmask;
    wb_ex             = retire & hd.ex;
    wb_ecode          = hd.ecode;
    wb_esubcode       = hd.esubcode;
    wb_pc             = hd.pc;
    wb_vaddr          = hd.vaddr;
    ertn_flush        = retire & hd.ertn;
    debug_wb_pc       = hd.pc;
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = hd.dest;
    debug_wb_rf_wdata = head_wdata;
    occupancy         = count;
  end

  // Forwarding: scan oldest to youngest so the youngest match wins
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && mem[idx].gr_we && !mem[idx].ex &&
          (mem[idx].dest == fwd_raddr) && (mem[idx].dest != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem[idx].rfrom_cntid ? cnt_tid : mem[idx].result;
      end
    end
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Bench for wb_retire_queue: directed scenarios followed by random traffic, all
// checked against a queue-based reference model.
module tb_wb_retire_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEST_W = 5;
  localparam int unsigned DEPTH  = 2;
`ifdef WB_TRACE_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic clk, resetn, in_valid, in_ready;
  logic [DATA_W-1:0] in_pc, in_result, in_vaddr, in_csr_wvalue, in_csr_wmask, cnt_tid;
  logic in_gr_we, in_rfrom_cntid, in_csr_we, in_ex, in_ertn;
  logic [DEST_W-1:0] in_dest;
  logic [13:0] in_csr_num;
  logic [5:0] in_ecode;
  logic [8:0] in_esubcode;
  logic rf_we, csr_we, wb_ex, ertn_flush, fwd_hit, trace_ready;
  logic [DEST_W-1:0] rf_waddr, fwd_raddr, debug_wb_rf_wnum;
  logic [DATA_W-1:0] rf_wdata, csr_wvalue, csr_wmask, wb_pc, wb_vaddr, fwd_data;
  logic [DATA_W-1:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [13:0] csr_num;
  logic [5:0] wb_ecode;
  logic [8:0] wb_esubcode;
  logic [3:0] debug_wb_rf_we;
  logic [$clog2(DEPTH):0] occupancy;

  wb_retire_queue #(.DATA_W(DATA_W), .DEST_W(DEST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_result(in_result), .in_vaddr(in_vaddr), .in_gr_we(in_gr_we),
    .in_dest(in_dest), .in_rfrom_cntid(in_rfrom_cntid), .in_csr_we(in_csr_we),
    .in_csr_num(in_csr_num), .in_csr_wvalue(in_csr_wvalue), .in_csr_wmask(in_csr_wmask),
    .in_ex(in_ex), .in_ecode(in_ecode), .in_esubcode(in_esubcode), .in_ertn(in_ertn),
    .cnt_tid(cnt_tid), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wvalue(csr_wvalue), .csr_wmask(csr_wmask),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .fwd_raddr(fwd_raddr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .trace_ready(trace_ready),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] pc, result, vaddr, csr_wv, csr_wm;
    logic              gr_we, rfrom, csr_we, ex, ertn;
    logic [DEST_W-1:0] dest;
    logic [13:0]       csr_num;
    logic [5:0]        ecode;
    logic [8:0]        esub;
  } ment_t;

  ment_t q[$];   // reference queue, index 0 = oldest
  ment_t cur;    // entry currently offered on the input
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ment_t blank();
    ment_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic ment_t rnd_ent();
    ment_t e;
    e.pc      = $urandom;
    e.result  = $urandom;
    e.vaddr   = $urandom;
    e.csr_wv  = $urandom;
    e.csr_wm  = $urandom;
    e.gr_we   = ($urandom_range(0, 3) != 0);
    e.rfrom   = ($urandom_range(0, 7) == 0);
    e.csr_we  = ($urandom_range(0, 3) == 0);
    e.ex      = ($urandom_range(0, 15) == 0);
    e.ertn    = ($urandom_range(0, 19) == 0);
    e.dest    = DEST_W'($urandom_range(0, 7));
    e.csr_num = 14'($urandom);
    e.ecode   = 6'($urandom);
    e.esub    = 9'($urandom);
    return e;
  endfunction

  task automatic set_in(input ment_t e);
    cur            = e;
    in_pc          = e.pc;
    in_result      = e.result;
    in_vaddr       = e.vaddr;
    in_gr_we       = e.gr_we;
    in_dest        = e.dest;
    in_rfrom_cntid = e.rfrom;
    in_csr_we      = e.csr_we;
    in_csr_num     = e.csr_num;
    in_csr_wvalue  = e.csr_wv;
    in_csr_wmask   = e.csr_wm;
    in_ex          = e.ex;
    in_ecode       = e.ecode;
    in_esubcode    = e.esub;
    in_ertn        = e.ertn;
  endtask

  // Check every output against the model, then advance one clock and update the model
  task automatic step();
    ment_t h;
    logic hv, ret, rdy, fl, push, we, cwe, fh;
    logic [DATA_W-1:0] hw, fd;
    #1;
    hv  = (q.size() > 0);
    h   = hv ? q[0] : blank();
    hw  = h.rfrom ? cnt_tid : h.result;
    ret = resetn && hv && (STALL ? trace_ready : 1'b1);
    rdy = (q.size() < int'(DEPTH)) || ret;
    fl  = ret && (h.ex || h.ertn);
    we  = ret && h.gr_we && !h.ex && !h.ertn;
    cwe = ret && h.csr_we && !h.ex && !h.ertn;
    fh  = 1'b0;
    fd  = '0;
    foreach (q[i]) begin
      if (q[i].gr_we && !q[i].ex && q[i].dest == fwd_raddr && q[i].dest != '0) begin
        fh = 1'b1;
        fd = q[i].rfrom ? cnt_tid : q[i].result;
      end
    end
    chk("in_ready", in_ready, rdy);
    chk("rf_we", rf_we, we);
    chk("csr_we", csr_we, cwe);
    chk("wb_ex", wb_ex, ret && h.ex);
    chk("ertn_flush", ertn_flush, ret && h.ertn);
    chk("debug_rf_we", debug_wb_rf_we, {4{we}});
    chk("occupancy", occupancy, q.size());
    chk("fwd_hit", fwd_hit, fh);
    chk("fwd_data", fwd_data, fd);
    if (hv) begin
      chk("rf_waddr", rf_waddr, h.dest);
      chk("rf_wdata", rf_wdata, hw);
      chk("csr_num", csr_num, h.csr_num);
      chk("csr_wvalue", csr_wvalue, h.csr_wv);
      chk("csr_wmask", csr_wmask, h.csr_wm);
      chk("wb_ecode", wb_ecode, h.ecode);
      chk("wb_esubcode", wb_esubcode, h.esub);
      chk("wb_pc", wb_pc, h.pc);
      chk("wb_vaddr", wb_vaddr, h.vaddr);
      chk("debug_pc", debug_wb_pc, h.pc);
      chk("debug_wnum", debug_wb_rf_wnum, h.dest);
      chk("debug_wdata", debug_wb_rf_wdata, hw);
    end
    push = in_valid && rdy;
    @(posedge clk);
    if (!resetn || fl) begin
      q.delete();
    end else begin
      if (ret) void'(q.pop_front());
      if (push) q.push_back(cur);
    end
    #1;
  endtask

  task automatic chk_zero();
    #1;
    chk("z_in_ready", in_ready, 1'b1);
    chk("z_rf_we", rf_we, 0);
    chk("z_rf_waddr", rf_waddr, 0);
    chk("z_rf_wdata", rf_wdata, 0);
    chk("z_csr_we", csr_we, 0);
    chk("z_csr_num", csr_num, 0);
    chk("z_csr_wvalue", csr_wvalue, 0);
    chk("z_csr_wmask", csr_wmask, 0);
    chk("z_wb_ex", wb_ex, 0);
    chk("z_wb_ecode", wb_ecode, 0);
    chk("z_wb_esubcode", wb_esubcode, 0);
    chk("z_wb_pc", wb_pc, 0);
    chk("z_wb_vaddr", wb_vaddr, 0);
    chk("z_ertn_flush", ertn_flush, 0);
    chk("z_fwd_hit", fwd_hit, 0);
    chk("z_fwd_data", fwd_data, 0);
    chk("z_debug_pc", debug_wb_pc, 0);
    chk("z_debug_rf_we", debug_wb_rf_we, 0);
    chk("z_debug_wnum", debug_wb_rf_wnum, 0);
    chk("z_debug_wdata", debug_wb_rf_wdata, 0);
    chk("z_occupancy", occupancy, 0);
  endtask

  initial begin
    ment_t e;
    resetn      = 1'b0;
    in_valid    = 1'b0;
    trace_ready = 1'b1;
    fwd_raddr   = '0;
    cnt_tid     = '0;
    set_in(blank());
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    chk_zero();

    // Simple push then retire next cycle
    e = blank(); e.pc = 32'h1c00_0000; e.dest = 5'd4; e.result = 32'h55; e.gr_we = 1'b1;
    set_in(e); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    chk("t1_rf_we", rf_we, 1'b1);
    chk("t1_rf_waddr", rf_waddr, 5'd4);
    chk("t1_rf_wdata", rf_wdata, 32'h55);
    chk("t1_occ_before", occupancy, 1);
    step();
    chk("t1_occ_after", occupancy, 0);

`ifdef WB_TRACE_STALL_EN
    // Back-pressure fills the queue, then drains in order
    trace_ready = 1'b0;
    e = blank(); e.gr_we = 1'b1; e.dest = 5'd1; e.result = 32'h101; e.pc = 32'h100;
    set_in(e); in_valid = 1'b1;
    step();
    e.dest = 5'd2; e.result = 32'h202; e.pc = 32'h104;
    set_in(e);
    step();
    in_valid = 1'b0;
    #1;
    chk("t2_occ_full", occupancy, 2);
    chk("t2_in_ready_full", in_ready, 1'b0);
    trace_ready = 1'b1;
    #1;
    chk("t2_first_waddr", rf_waddr, 5'd1);
    step();
    chk("t2_second_waddr", rf_waddr, 5'd2);
    step();
    chk("t2_in_ready_drained", in_ready, 1'b1);
`endif

    // Exception at head kills a younger writer
    trace_ready = 1'b0;
    e = blank(); e.ex = 1'b1; e.ecode = 6'h08; e.pc = 32'h200; e.gr_we = 1'b1; e.dest = 5'd6;
    set_in(e); in_valid = 1'b1;
    step();
    e = blank(); e.gr_we = 1'b1; e.dest = 5'd7; e.result = 32'h77; e.pc = 32'h204;
    set_in(e);
`ifdef WB_TRACE_STALL_EN
    step();
    in_valid    = 1'b0;
    trace_ready = 1'b1;
`endif
    #1;
    chk("t3_wb_ex", wb_ex, 1'b1);
    chk("t3_rf_we", rf_we, 1'b0);
    chk("t3_ecode", wb_ecode, 6'h08);
    step();
    in_valid = 1'b0;
    #1;
    chk("t3_occ_flushed", occupancy, 0);
    chk("t3_no_young_write", rf_we, 1'b0);
    step();
    trace_ready = 1'b1;

    // Forwarding picks the youngest pending write
    e = blank(); e.gr_we = 1'b1; e.dest = 5'd5; e.result = 32'h11;
`ifdef WB_TRACE_STALL_EN
    trace_ready = 1'b0;
    set_in(e); in_valid = 1'b1;
    step();
    e.result = 32'h22;
    set_in(e);
    step();
    in_valid  = 1'b0;
    fwd_raddr = 5'd5;
    #1;
    chk("t4_fwd_hit", fwd_hit, 1'b1);
    chk("t4_fwd_data", fwd_data, 32'h22);
`else
    set_in(e); in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    fwd_raddr = 5'd5;
    #1;
    chk("t4_fwd_hit", fwd_hit, 1'b1);
    chk("t4_fwd_data", fwd_data, 32'h11);
`endif
    fwd_raddr = 5'd0;
    #1;
    chk("t4_fwd_r0", fwd_hit, 1'b0);
    trace_ready = 1'b1;
    step();
    step();

    // Counter result and ertn suppressing a CSR write
    e = blank(); e.gr_we = 1'b1; e.dest = 5'd3; e.result = 32'h1234; e.rfrom = 1'b1;
    set_in(e); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cnt_tid  = 32'hABCD;
    #1;
    chk("t5_cnt_wdata", rf_wdata, 32'hABCD);
    chk("t5_cnt_we", rf_we, 1'b1);
    step();
    e = blank(); e.csr_we = 1'b1; e.ertn = 1'b1; e.csr_num = 14'h6; e.csr_wv = 32'h5a;
    set_in(e); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    chk("t5_csr_we", csr_we, 1'b0);
    chk("t5_ertn_flush", ertn_flush, 1'b1);
    step();
    chk("t5_occ", occupancy, 0);

    // Reset while the queue holds entries
    trace_ready = 1'b0;
    e = blank(); e.gr_we = 1'b1; e.dest = 5'd9; e.result = 32'h99; e.pc = 32'h300;
    set_in(e); in_valid = 1'b1;
    step();
    step();
    resetn = 1'b0;
    step();
    resetn   = 1'b1;
    in_valid = 1'b0;
    set_in(blank());
    chk_zero();
    trace_ready = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 1000; n++) begin
      resetn      = ($urandom_range(0, 99) != 0);
      in_valid    = ($urandom_range(0, 9) < 7);
      trace_ready = ($urandom_range(0, 9) < 6);
      fwd_raddr   = DEST_W'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) cnt_tid = $urandom;
      set_in(rnd_ent());
      step();
    end
    resetn   = 1'b1;
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
